// File: rtl/nx_im_capture_tap.sv
// rtl/nx_im_capture_tap.sv - passive stream tap that frames snooped beats into monitor words
// Never stalls the observed bus; overflow drops beats and a synthetic eob word closes the frame.
module nx_im_capture_tap #(
    parameter  int N_TAP_BITS = 24,
    parameter  int N_SEQ_BITS = 6,
    parameter  int N_MAX_BITS = 8,
    localparam int IM_W       = N_TAP_BITS + N_SEQ_BITS + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic                  cfg_single_shot,
    input  logic                  cfg_rearm,
    input  logic [N_MAX_BITS-1:0] cfg_max_words,
    input  logic                  tap_vld,
    input  logic                  tap_rdy,
    input  logic [N_TAP_BITS-1:0] tap_dat,
    input  logic                  tap_eop,
    output logic [IM_W-1:0]       im_din,
    output logic                  im_vld,
    input  logic                  im_rdy,
    output logic [1:0]            stat_state,
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_drops
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  sof_q;
    logic                  pend_q, pend_d;
    logic                  cnt_drops_q, cnt_drops_d;
    logic [N_SEQ_BITS-1:0] seq_q;
    logic [N_MAX_BITS-1:0] wc_q, wc_d, wc_inc;

    logic [IM_W-1:0]       buf_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic                  beat, pop, can_push, take, trunc_hit;
    logic                  push, push_eob, push_trunc, drop_inc;
    logic [N_TAP_BITS-1:0] push_data;
    logic [1:0]            close_state;

    assign beat        = tap_vld & tap_rdy;
    assign im_vld      = (count_q != 2'd0);
    assign im_din      = im_vld ? buf_q[rd_ptr_q] : '0;
    assign pop         = im_vld & im_rdy;
    assign can_push    = (count_q != 2'd2) | pop;
    assign close_state = cfg_single_shot ? ST_DONE : ST_IDLE;
    assign stat_state  = state_q;

    // Word count saturates so an unlimited frame can never alias onto a later limit.
    assign wc_inc    = (state_q == ST_IDLE) ? N_MAX_BITS'(1)
                     : ((wc_q == '1) ? wc_q : wc_q + 1'b1);
    assign trunc_hit = (cfg_max_words != '0) && (wc_inc == cfg_max_words) && !tap_eop;
    assign take      = beat && (((state_q == ST_IDLE) && sof_q && cfg_enable) || (state_q == ST_CAP));

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_drops_d = cnt_drops_q;
        wc_d        = wc_q;
        push        = 1'b0;
        push_eob    = 1'b0;
        push_trunc  = 1'b0;
        push_data   = '0;
        drop_inc    = 1'b0;

        if (pend_q && can_push) begin
            push       = 1'b1;
            push_eob   = 1'b1;
            push_trunc = 1'b1;
            pend_d     = 1'b0;
        end

        if (take) begin
            if (pend_q || !can_push) begin
                // Only a frame that already emitted words needs a synthetic close.
                drop_inc    = 1'b1;
                cnt_drops_d = 1'b1;
                if (state_q == ST_CAP) begin
                    pend_d = 1'b1;
                end
                state_d = tap_eop ? close_state : ST_DROP;
            end else begin
                push        = 1'b1;
                push_eob    = tap_eop | trunc_hit;
                push_trunc  = trunc_hit;
                push_data   = tap_dat;
                wc_d        = wc_inc;
                cnt_drops_d = 1'b0;
                state_d     = tap_eop ? close_state : (trunc_hit ? ST_DROP : ST_CAP);
            end
        end else if ((state_q == ST_DROP) && beat) begin
            drop_inc = cnt_drops_q;
            if (tap_eop) begin
                state_d = close_state;
            end
        end else if ((state_q == ST_DONE) && cfg_rearm) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sof_q       <= 1'b1;
            pend_q      <= 1'b0;
            cnt_drops_q <= 1'b0;
            seq_q       <= '0;
            wc_q        <= '0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            stat_frames <= 16'd0;
            stat_drops  <= 16'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_drops_q <= cnt_drops_d;
            wc_q        <= wc_d;
            if (beat) begin
                sof_q <= tap_eop;
            end
            if (push) begin
                buf_q[wr_ptr_q] <= {push_eob, push_trunc, seq_q, push_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
            if (push && push_eob) begin
                seq_q <= seq_q + 1'b1;
                if (stat_frames != 16'hFFFF) begin
                    stat_frames <= stat_frames + 16'd1;
                end
            end
            if (drop_inc && (stat_drops != 16'hFFFF)) begin
                stat_drops <= stat_drops + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nx_im_capture_tap.sv
// tb/tb_nx_im_capture_tap.sv - directed and randomized checks of nx_im_capture_tap
module tb_nx_im_capture_tap;

    localparam int NT = 24;
    localparam int NS = 6;
    localparam int NM = 8;
    localparam int IW = NT + NS + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable, cfg_single_shot, cfg_rearm;
    logic [NM-1:0] cfg_max_words;
    logic          tap_vld, tap_rdy, tap_eop;
    logic [NT-1:0] tap_dat;
    logic [IW-1:0] im_din;
    logic          im_vld, im_rdy;
    logic [1:0]    stat_state;
    logic [15:0]   stat_frames, stat_drops;

    always #5 clk = ~clk;

    nx_im_capture_tap dut (
        .clk(clk), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_single_shot(cfg_single_shot),
        .cfg_rearm(cfg_rearm), .cfg_max_words(cfg_max_words),
        .tap_vld(tap_vld), .tap_rdy(tap_rdy), .tap_dat(tap_dat), .tap_eop(tap_eop),
        .im_din(im_din), .im_vld(im_vld), .im_rdy(im_rdy),
        .stat_state(stat_state), .stat_frames(stat_frames), .stat_drops(stat_drops)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame-level bookkeeping over a queue standing in for the monitor buffer.
    logic [IW-1:0] m_q[$];
    logic [IW-1:0] got[$];
    bit            m_sof, m_pend, m_cnt;
    int            m_mode, m_wc, m_frames, m_drops;
    logic [NS-1:0] m_seq;

    function automatic logic [IW-1:0] mk(bit eob, bit tr, logic [NS-1:0] seq, logic [NT-1:0] d);
        return {eob, tr, seq, d};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sof = 1; m_pend = 0; m_cnt = 0;
        m_mode = 0; m_wc = 0; m_frames = 0; m_drops = 0; m_seq = '0;
    endtask

    task automatic model_step();
        bit b, eop, pop_now, pushed, pend0, tr;
        int free, nmode, nwc, close;
        logic [IW-1:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        b       = tap_vld & tap_rdy;
        eop     = tap_eop;
        pop_now = (m_q.size() != 0) && im_rdy;
        free    = 2 - m_q.size() + (pop_now ? 1 : 0);
        close   = cfg_single_shot ? 3 : 0;
        pend0   = m_pend;
        pushed  = 0;
        nmode   = m_mode;
        w       = '0;
        if (m_pend && free > 0) begin
            w = mk(1, 1, m_seq, '0);
            pushed = 1;
            m_pend = 0;
        end
        if (b && ((m_mode == 0 && m_sof && cfg_enable) || m_mode == 1)) begin
            nwc = (m_mode == 0) ? 1 : ((m_wc < 255) ? m_wc + 1 : 255);
            if (pend0 || free == 0) begin
                if (m_drops < 65535) m_drops++;
                m_cnt = 1;
                if (m_mode == 1) m_pend = 1;
                nmode = eop ? close : 2;
            end else begin
                tr = (cfg_max_words != 0) && (nwc == int'(cfg_max_words)) && !eop;
                w = mk(eop | tr, tr, m_seq, tap_dat);
                pushed = 1;
                m_wc = nwc;
                m_cnt = 0;
                nmode = eop ? close : (tr ? 2 : 1);
            end
        end else if (b && m_mode == 2) begin
            if (m_cnt && m_drops < 65535) m_drops++;
            if (eop) nmode = close;
        end else if (m_mode == 3 && cfg_rearm) begin
            nmode = 0;
        end
        if (pop_now) void'(m_q.pop_front());
        if (pushed) begin
            m_q.push_back(w);
            if (w[IW-1]) begin
                m_seq = m_seq + 1'b1;
                if (m_frames < 65535) m_frames++;
            end
        end
        if (b) m_sof = eop;
        m_mode = nmode;
    endtask

    task automatic step();
        model_step();
        if (im_vld && im_rdy) got.push_back(im_din);
        @(posedge clk);
        #1;
    endtask

    task automatic beat_t(input logic [NT-1:0] d, input bit eop);
        tap_vld = 1; tap_rdy = 1; tap_dat = d; tap_eop = eop;
        step();
        tap_vld = 0; tap_eop = 0; tap_dat = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
        got.delete();
    endtask

    task automatic test_reset();
        rst = 1; tap_vld = 1; tap_rdy = 1; tap_dat = 24'hABCDEF;
        step();
        tap_vld = 0; tap_rdy = 0; tap_dat = '0;
        n_cmp++; if (im_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", im_vld); end
        n_cmp++; if (im_din !== '0) begin n_bad++; $display("FAIL reset_din got %h want 0", im_din); end
        n_cmp++; if (stat_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", stat_state); end
        n_cmp++; if (stat_frames !== 16'd0 || stat_drops !== 16'd0) begin
            n_bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_frames, stat_drops); end
        rst = 0;
    endtask

    task automatic test_basic_frame();
        logic [NT-1:0] d;
        do_reset();
        cfg_enable = 1; cfg_max_words = 0; im_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            d = NT'($urandom);
            beat_t(d, i == 3);
            n_cmp++; if (im_vld !== 1'b1 || im_din !== mk(i == 3, 0, 0, d)) begin
                n_bad++; $display("FAIL basic_word%0d got %b/%h want 1/%h", i, im_vld, im_din, mk(i == 3, 0, 0, d)); end
        end
        step();
        n_cmp++; if (im_vld !== 1'b0) begin n_bad++; $display("FAIL basic_drain got %b want 0", im_vld); end
        n_cmp++; if (stat_frames !== 16'd1) begin n_bad++; $display("FAIL basic_frames got %0d want 1", stat_frames); end
    endtask

    task automatic test_truncate();
        logic [NT-1:0] ds [10];
        do_reset();
        cfg_enable = 1; cfg_max_words = 3; im_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            ds[i] = NT'($urandom);
            beat_t(ds[i], i == 9);
        end
        repeat (3) step();
        n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL trunc_count got %0d want 3", got.size()); end
        else begin
            n_cmp++; if (got[0] !== mk(0, 0, 0, ds[0])) begin n_bad++; $display("FAIL trunc_w0 got %h want %h", got[0], mk(0, 0, 0, ds[0])); end
            n_cmp++; if (got[2] !== mk(1, 1, 0, ds[2])) begin n_bad++; $display("FAIL trunc_w2 got %h want %h", got[2], mk(1, 1, 0, ds[2])); end
        end
        n_cmp++; if (stat_drops !== 16'd0) begin n_bad++; $display("FAIL trunc_drops got %0d want 0", stat_drops); end
        n_cmp++; if (stat_state !== 2'd0) begin n_bad++; $display("FAIL trunc_state got %0d want 0", stat_state); end
        cfg_max_words = 0;
    endtask

    task automatic test_overflow();
        logic [NT-1:0] ds [5];
        logic [NT-1:0] d;
        do_reset();
        cfg_enable = 1; im_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            ds[i] = NT'($urandom);
            beat_t(ds[i], i == 4);
        end
        n_cmp++; if (stat_drops !== 16'd3) begin n_bad++; $display("FAIL ovf_drops got %0d want 3", stat_drops); end
        n_cmp++; if (stat_state !== 2'd0) begin n_bad++; $display("FAIL ovf_state got %0d want 0", stat_state); end
        im_rdy = 1;
        repeat (4) step();
        n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL ovf_count got %0d want 3", got.size()); end
        else begin
            n_cmp++; if (got[1] !== mk(0, 0, 0, ds[1])) begin n_bad++; $display("FAIL ovf_w1 got %h want %h", got[1], mk(0, 0, 0, ds[1])); end
            n_cmp++; if (got[2] !== mk(1, 1, 0, '0)) begin n_bad++; $display("FAIL ovf_synth got %h want %h", got[2], mk(1, 1, 0, '0)); end
        end
        n_cmp++; if (stat_frames !== 16'd1) begin n_bad++; $display("FAIL ovf_frames got %0d want 1", stat_frames); end
        d = NT'($urandom);
        beat_t(d, 1);
        n_cmp++; if (im_din !== mk(1, 0, 1, d)) begin n_bad++; $display("FAIL ovf_nextseq got %h want %h", im_din, mk(1, 0, 1, d)); end
    endtask

    task automatic test_single_shot();
        logic [NT-1:0] a1, c1;
        do_reset();
        cfg_enable = 1; cfg_single_shot = 1; im_rdy = 1;
        a1 = NT'($urandom); c1 = NT'($urandom);
        beat_t(NT'($urandom), 0); beat_t(a1, 1);
        beat_t(NT'($urandom), 0); beat_t(NT'($urandom), 1);
        repeat (3) step();
        n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL ss_count got %0d want 2", got.size()); end
        else begin
            n_cmp++; if (got[1] !== mk(1, 0, 0, a1)) begin n_bad++; $display("FAIL ss_last got %h want %h", got[1], mk(1, 0, 0, a1)); end
        end
        n_cmp++; if (stat_state !== 2'd3) begin n_bad++; $display("FAIL ss_done got %0d want 3", stat_state); end
        cfg_rearm = 1; step(); cfg_rearm = 0;
        n_cmp++; if (stat_state !== 2'd0) begin n_bad++; $display("FAIL ss_rearm got %0d want 0", stat_state); end
        beat_t(NT'($urandom), 0); beat_t(c1, 1);
        repeat (3) step();
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL ss_count2 got %0d want 4", got.size()); end
        else begin
            n_cmp++; if (got[3] !== mk(1, 0, 1, c1)) begin n_bad++; $display("FAIL ss_second got %h want %h", got[3], mk(1, 0, 1, c1)); end
        end
        cfg_single_shot = 0; cfg_rearm = 1; step(); cfg_rearm = 0;
    endtask

    task automatic test_mid_stream();
        do_reset();
        cfg_enable = 0; im_rdy = 1;
        beat_t(NT'($urandom), 0);
        cfg_enable = 1;
        beat_t(NT'($urandom), 0);
        beat_t(NT'($urandom), 1);
        step();
        n_cmp++; if (im_vld !== 1'b0 || got.size() != 0) begin
            n_bad++; $display("FAIL mid_capture got vld=%b words=%0d want 0/0", im_vld, got.size()); end
        n_cmp++; if (stat_drops !== 16'd0 || stat_frames !== 16'd0) begin
            n_bad++; $display("FAIL mid_stats got %0d/%0d want 0/0", stat_frames, stat_drops); end
    endtask

    task automatic test_seq_wrap();
        logic [NT-1:0] d;
        do_reset();
        cfg_enable = 1; im_rdy = 1;
        for (int i = 0; i < 64; i++) beat_t(NT'($urandom), 1);
        step();
        n_cmp++; if (stat_frames !== 16'd64) begin n_bad++; $display("FAIL wrap_frames got %0d want 64", stat_frames); end
        d = NT'($urandom);
        beat_t(d, 1);
        n_cmp++; if (im_din !== mk(1, 0, 0, d)) begin n_bad++; $display("FAIL wrap_seq got %h want %h", im_din, mk(1, 0, 0, d)); end
    endtask

    task automatic test_reset_mid_frame();
        logic [NT-1:0] d;
        do_reset();
        cfg_enable = 1; im_rdy = 1;
        beat_t(NT'($urandom), 1);
        step();
        im_rdy = 0;
        beat_t(NT'($urandom), 0);
        n_cmp++; if (stat_state !== 2'd1 || im_vld !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_pre got state=%0d vld=%b want 1/1", stat_state, im_vld); end
        rst = 1; step(); rst = 0;
        n_cmp++; if (im_vld !== 1'b0 || stat_state !== 2'd0 || stat_frames !== 16'd0 || stat_drops !== 16'd0) begin
            n_bad++; $display("FAIL rstmid_post got vld=%b state=%0d frames=%0d drops=%0d want 0/0/0/0",
                              im_vld, stat_state, stat_frames, stat_drops); end
        im_rdy = 1;
        d = NT'($urandom);
        beat_t(d, 1);
        n_cmp++; if (im_din !== mk(1, 0, 0, d)) begin n_bad++; $display("FAIL rstmid_next got %h want %h", im_din, mk(1, 0, 0, d)); end
    endtask

    task automatic test_random();
        logic [IW-1:0] exp_din;
        logic [NM-1:0] maxes [6];
        maxes = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst             = ($urandom_range(0, 499) == 0);
            cfg_enable      = ($urandom_range(0, 9) != 0);
            cfg_single_shot = ($urandom_range(0, 9) == 0);
            cfg_rearm       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) cfg_max_words = maxes[$urandom_range(0, 5)];
            tap_vld         = ($urandom_range(0, 3) != 0);
            tap_rdy         = ($urandom_range(0, 3) != 0);
            tap_eop         = ($urandom_range(0, 2) == 0);
            tap_dat         = NT'($urandom);
            im_rdy          = ($urandom_range(0, 2) != 0);
            step();
            exp_din = (m_q.size() != 0) ? m_q[0] : '0;
            n_cmp++;
            if ({im_vld, im_din, stat_state, stat_frames, stat_drops} !==
                {m_q.size() != 0, exp_din, 2'(m_mode), 16'(m_frames), 16'(m_drops)}) begin
                n_bad++;
                $display("FAIL random cyc%0d got vld=%b din=%h st=%0d fr=%0d dr=%0d want vld=%b din=%h st=%0d fr=%0d dr=%0d",
                         cyc, im_vld, im_din, stat_state, stat_frames, stat_drops,
                         m_q.size() != 0, exp_din, m_mode, m_frames, m_drops);
            end
        end
        rst = 0; tap_vld = 0; tap_eop = 0; cfg_rearm = 0;
    endtask

    initial begin
        rst = 1; cfg_enable = 0; cfg_single_shot = 0; cfg_rearm = 0; cfg_max_words = '0;
        tap_vld = 0; tap_rdy = 0; tap_dat = '0; tap_eop = 0; im_rdy = 0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_truncate();
        test_overflow();
        test_single_shot();
        test_mid_stream();
        test_seq_wrap();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
